// File: rtl/shifter_pkg.sv
// Shared encodings for the iterative shifter: shift modes and controller states.
package shifter_pkg;

    localparam logic [1:0] MODE_LOGICAL = 2'b00;
    localparam logic [1:0] MODE_ARITH   = 2'b01;
    localparam logic [1:0] MODE_ROTATE  = 2'b10;
    localparam logic [1:0] MODE_ROTC    = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

endpackage

// File: rtl/shift_step.sv
// Combinational single-position shift/rotate step; chaining W-1 of these
// would give a fully unrolled shifter.
module shift_step
    import shifter_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [W-1:0] i_data,
    input  logic         i_carry,
    input  logic         i_right,
    input  logic [1:0]   i_mode,
    output logic [W-1:0] o_data,
    output logic         o_carry
);

    logic w_fill;

    always_comb begin
        w_fill  = 1'b0;
        o_data  = i_data;
        o_carry = i_carry;
        if (i_right) begin
            case (i_mode)
                MODE_ARITH:  w_fill = i_data[W-1];
                MODE_ROTATE: w_fill = i_data[0];
                MODE_ROTC:   w_fill = i_carry;
                default:     w_fill = 1'b0;
            endcase
            o_carry = i_data[0];
            o_data  = {w_fill, i_data[W-1:1]};
        end else begin
            // Left arithmetic shift fills with zero, same as logical.
            case (i_mode)
                MODE_ROTATE: w_fill = i_data[W-1];
                MODE_ROTC:   w_fill = i_carry;
                default:     w_fill = 1'b0;
            endcase
            o_carry = i_data[W-1];
            o_data  = {i_data[W-2:0], w_fill};
        end
    end

endmodule

// File: rtl/seq_shifter.sv
// Iterative shifter: one bit position per clock, launched by start, reports
// completion with a one-cycle done pulse. Results are held until the next launch.
module seq_shifter
    import shifter_pkg::*;
#(
    parameter int W  = 8,
    parameter int CW = $clog2(W)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [W-1:0]  in,
    input  logic [CW-1:0] count,
    input  logic          right,
    input  logic [1:0]    mode,
    input  logic          cin,
    output logic [W-1:0]  out,
    output logic          co,
    output logic          zero,
    output logic          busy,
    output logic          done,
    output logic [1:0]    dbg_state
);

    state_t        r_state;
    state_t        w_next_state;
    logic [W-1:0]  r_out;
    logic          r_co;
    logic          r_zero;
    logic [CW-1:0] r_cnt;
    logic          r_right;
    logic [1:0]    r_mode;
    logic [W-1:0]  w_step_data;
    logic          w_step_carry;

    shift_step #(.W(W)) u_step (
        .i_data  (r_out),
        .i_carry (r_co),
        .i_right (r_right),
        .i_mode  (r_mode),
        .o_data  (w_step_data),
        .o_carry (w_step_carry)
    );

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next_state = (count == '0) ? ST_DONE : ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (r_cnt == CW'(1)) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE:  w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_out   <= '0;
            r_co    <= 1'b0;
            r_zero  <= 1'b1;
            r_cnt   <= '0;
            r_right <= 1'b0;
            r_mode  <= MODE_LOGICAL;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_out   <= in;
                        r_co    <= cin;
                        r_zero  <= (in == '0);
                        r_cnt   <= count;
                        r_right <= right;
                        r_mode  <= mode;
                    end
                end
                ST_SHIFT: begin
                    r_out  <= w_step_data;
                    r_co   <= w_step_carry;
                    r_zero <= (w_step_data == '0);
                    r_cnt  <= r_cnt - CW'(1);
                end
                default: begin
                end
            endcase
        end
    end

    // All outputs come straight from registers: no input-to-output path.
    assign out       = r_out;
    assign co        = r_co;
    assign zero      = r_zero;
    assign busy      = (r_state != ST_IDLE);
    assign done      = (r_state == ST_DONE);
    assign dbg_state = r_state;

endmodule

// File: tb/tb_seq_shifter.sv
// Randomized and directed bench for seq_shifter with a queue-based scoreboard
// fed by the driver and drained by a done-triggered monitor.
module tb_seq_shifter;
    import shifter_pkg::*;

    localparam int W  = 8;
    localparam int CW = $clog2(W);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          t_start;
    logic [W-1:0]  t_in;
    logic [CW-1:0] t_count;
    logic          t_right;
    logic [1:0]    t_mode;
    logic          t_cin;
    logic [W-1:0]  t_out;
    logic          t_co;
    logic          t_zero;
    logic          t_busy;
    logic          t_done;
    logic [1:0]    t_dbg_state;

    seq_shifter #(.W(W), .CW(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (t_start),
        .in        (t_in),
        .count     (t_count),
        .right     (t_right),
        .mode      (t_mode),
        .cin       (t_cin),
        .out       (t_out),
        .co        (t_co),
        .zero      (t_zero),
        .busy      (t_busy),
        .done      (t_done),
        .dbg_state (t_dbg_state)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    // Scoreboard state
    logic [W:0] exp_q[$];
    int         exp_cyc_q[$];
    int         checks   = 0;
    int         fails    = 0;
    int         launched = 0;
    int         dones    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: whole-operation result {co, out} from plain shifts and
    // rotations of the operand (or of the (W+1)-bit ring for ROTC).
    function automatic logic [W:0] model(input logic [W-1:0] a, input int n,
                                         input logic r, input logic [1:0] m,
                                         input logic c);
        logic [W-1:0]       o;
        logic               cb;
        logic [2*W-1:0]     dbl;
        logic [2*W+1:0]     dring;
        logic [W:0]         res;
        if (n == 0) return {c, a};
        cb = r ? a[n-1] : a[W-n];
        dbl = {a, a};
        case (m)
            MODE_LOGICAL: o = r ? (a >> n) : (a << n);
            MODE_ARITH:   o = r ? W'($signed(a) >>> n) : (a << n);
            MODE_ROTATE: begin
                if (r) o = W'(dbl >> n);
                else   o = W'((dbl << n) >> W);
            end
            default: begin
                dring = {c, a, c, a};
                if (r) res = (W+1)'(dring >> n);
                else   res = (W+1)'((dring << n) >> (W+1));
                return res;
            end
        endcase
        return {cb, o};
    endfunction

    // Monitor: every done pulse is checked against the oldest expectation.
    always @(negedge clk) begin
        logic [W:0] e;
        int         ec;
        if (t_done === 1'b1) begin
            dones++;
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 32'(t_out), 32'hFFFF_FFFF);
            end else begin
                e  = exp_q.pop_front();
                ec = exp_cyc_q.pop_front();
                chk("out", 32'(t_out), 32'(e[W-1:0]));
                chk("co", 32'(t_co), 32'(e[W]));
                chk("zero", 32'(t_zero), 32'(e[W-1:0] == '0));
                chk("done_cycle", 32'(cyc), 32'(ec));
            end
        end
    end

    // Driver tasks
    task automatic launch(input logic [W-1:0] a, input int n, input logic r,
                          input logic [1:0] m, input logic c, input bit push);
        @(negedge clk);
        t_in    = a;
        t_count = CW'(n);
        t_right = r;
        t_mode  = m;
        t_cin   = c;
        t_start = 1'b1;
        if (push) begin
            exp_q.push_back(model(a, n, r, m, c));
            exp_cyc_q.push_back(cyc + n + 1);
            launched++;
        end
        @(posedge clk);
        #1;
        t_start = 1'b0;
        t_in    = W'($urandom);
        t_count = CW'($urandom);
        t_right = 1'($urandom);
        t_mode  = 2'($urandom);
        t_cin   = 1'($urandom);
        @(negedge clk);
        chk("busy_after_launch", 32'(t_busy), 32'd1);
    endtask

    task automatic wait_idle();
        int k;
        for (k = 0; k < 2 * W + 4; k++) begin
            if (t_busy === 1'b0) break;
            @(negedge clk);
        end
        if (k == 2 * W + 4) chk("idle_timeout", 32'(t_busy), 32'd0);
    endtask

    initial begin
        rst_n   = 1'b0;
        t_start = 1'b0;
        t_in    = '0;
        t_count = '0;
        t_right = 1'b0;
        t_mode  = MODE_LOGICAL;
        t_cin   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(t_busy), 32'd0);
        chk("rst_done", 32'(t_done), 32'd0);
        chk("rst_out", 32'(t_out), 32'd0);
        chk("rst_co", 32'(t_co), 32'd0);
        chk("rst_zero", 32'(t_zero), 32'd1);
        rst_n = 1'b1;

        // Directed scenarios
        launch(8'h96, 3, 1'b1, MODE_ARITH, 1'b0, 1'b1);
        wait_idle();
        chk("hold_arith_out", 32'(t_out), 32'hF2);
        chk("hold_arith_co", 32'(t_co), 32'd1);

        launch(8'h81, 1, 1'b0, MODE_ROTATE, 1'b0, 1'b1);
        wait_idle();
        chk("rot_left_out", 32'(t_out), 32'h03);

        launch(8'h02, 2, 1'b1, MODE_ROTC, 1'b1, 1'b1);
        @(negedge clk);
        chk("rotc_mid_out", 32'(t_out), 32'h81);
        chk("rotc_mid_co", 32'(t_co), 32'd0);
        wait_idle();
        chk("rotc_out", 32'(t_out), 32'h40);
        chk("rotc_co", 32'(t_co), 32'd1);

        launch(8'hFF, 7, 1'b0, MODE_LOGICAL, 1'b0, 1'b1);
        wait_idle();
        chk("lsl7_out", 32'(t_out), 32'h80);
        launch(8'h01, 1, 1'b1, MODE_LOGICAL, 1'b0, 1'b1);
        wait_idle();
        chk("lsr1_zero", 32'(t_zero), 32'd1);
        chk("lsr1_co", 32'(t_co), 32'd1);

        launch(8'h5A, 0, 1'b0, MODE_LOGICAL, 1'b1, 1'b1);
        wait_idle();
        chk("cnt0_out", 32'(t_out), 32'h5A);

        // start pulsed mid-shift must be ignored
        launch(8'hC3, 5, 1'b1, MODE_ROTATE, 1'b0, 1'b1);
        @(negedge clk);
        t_start = 1'b1;
        @(negedge clk);
        t_start = 1'b0;
        wait_idle();
        @(negedge clk);
        chk("no_queued_start", 32'(t_busy), 32'd0);

        // Reset in the third SHIFT cycle of a count-6 operation
        launch(8'hA5, 6, 1'b0, MODE_ARITH, 1'b1, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_busy", 32'(t_busy), 32'd0);
        chk("midrst_out", 32'(t_out), 32'd0);
        chk("midrst_co", 32'(t_co), 32'd0);
        chk("midrst_zero", 32'(t_zero), 32'd1);
        chk("midrst_done", 32'(t_done), 32'd0);
        chk("midrst_state", 32'(t_dbg_state), 32'(ST_IDLE));

        // start coincident with reset is not launched
        t_start = 1'b1;
        t_count = 3'd2;
        @(negedge clk);
        t_start = 1'b0;
        rst_n   = 1'b1;
        @(negedge clk);
        chk("start_in_reset", 32'(t_busy), 32'd0);

        launch(8'h3C, 4, 1'b1, MODE_LOGICAL, 1'b0, 1'b1);
        wait_idle();

        // Randomized operations
        for (int i = 0; i < 300; i++) begin
            launch(W'($urandom), $urandom_range(0, W - 1), 1'($urandom),
                   2'($urandom_range(0, 3)), 1'($urandom), 1'b1);
            wait_idle();
        end

        repeat (3) @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        chk("done_count", 32'(dones), 32'(launched));
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule

// File: doc/seq_shifter.md
# seq_shifter

Parametrised, iterative barrel-replacement shifter: shifts a W-bit operand one bit position per clock for a requested count, in logical, arithmetic, rotate or rotate-through-carry mode, in either direction. It is the clocked successor to the team's 8-bit combinational shift/rotate unit and sits beside the ALU in the datapath. The controller launches it with a start/busy/done handshake. Results and flags are registered and held until the next operation.

## Interface
Parameters:
- `W`, 8: operand width, ≥ 2.
- `CW`, `$clog2(W)`: count width; legal counts 0..W-1.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset; one clock; reset is synchronous and active-low.
- `start`  in  1  launch request; sampled only in IDLE.
- `in`  in  W  operand.
- `count`  in  CW  shift distance.
- `right`  in  1  1 = shift right, 0 = shift left.
- `mode`  in  2  00 LOGICAL, 01 ARITH, 10 ROTATE, 11 ROTC (rotate through carry).
- `cin`  in  1  initial carry value; used by ROTC and as the count-0 carry.
- `out`  out  W  result register.
- `co`  out  1  last bit shifted out.
- `zero`  out  1  `out == 0`, registered with `out`.
- `busy`  out  1  high whenever state ≠ IDLE.
- `done`  out  1  one-cycle pulse; result valid.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- **IDLE, `start`=1:** load `out` ← `in`, `co` ← `cin`, and remaining counter ← `count`. Latch `right` and `mode`. Next state is DONE if `count`=0, otherwise SHIFT.
- **IDLE, `start`=0:** hold all registers.
- **SHIFT:** perform one step per cycle and decrement the counter. When the counter reaches 1, step and go to DONE.
- **DONE:** `done`=1 for this cycle only. Next state is IDLE.
- **Step, right direction:**
  - Bit leaving is `out[0]`, which goes to `co`.
  - Fill bit: LOGICAL 0; ARITH `out[W-1]`; ROTATE `out[0]`; ROTC old `co`.
- **Step, left direction:**
  - Bit leaving is `out[W-1]`, which goes to `co`.
  - Fill bit: LOGICAL 0; ARITH 0; ROTATE `out[W-1]`; ROTC old `co`.
- ROTC therefore rotates a (W+1)-bit ring {`co`, `out`}.
- `zero` tracks `out` after every load or step.
- `start` in SHIFT or DONE is ignored, not queued.
- Operands and inputs may change freely after the launch cycle; only latched copies are used.
- **Reset** (any state, including mid-shift): next edge gives state IDLE, `out`=0, `co`=0, `zero`=1, `busy`=0, `done`=0, counter=0.

## Timing
- Launch edge is the end of the IDLE cycle with `start`=1. `busy` rises the following cycle.
- `done` is high in cycle `count`+1 after the launch cycle (count 0 → 1 cycle; count W-1 → W cycles).
- In the `done` cycle, `out`, `co` and `zero` hold the final result. They remain stable until the next launch edge.
- Earliest back-to-back `start` is the cycle after `done` (state IDLE). Throughput is one operation per `count`+2 cycles.
- `start` coincident with `rst_n`=0: reset wins and the operation is not launched.
- No combinational path from inputs to outputs.

## Structure
- Shared package `shifter_pkg`:
  - mode encodings `MODE_LOGICAL`, `MODE_ARITH`, `MODE_ROTATE`, `MODE_ROTC`;
  - state encodings `ST_IDLE`, `ST_SHIFT`, `ST_DONE`.
- Sub-module `shift_step`: purely combinational single-bit step, parametrised by W.
  - Inputs: data, carry, `right`, `mode`.
  - Outputs: next data, next carry.
  - Reusable by a future fully-unrolled variant.
- Top level contains the FSM, the counter, and the `out`/`co`/`zero` registers.

## Test plan
All scenarios use W=8.
- `in`=0x96, ARITH, right, `count`=3 → `done` in cycle 4; `out`=0xF2, `co`=1, `zero`=0.
- `in`=0x81, ROTATE, left, `count`=1 → `out`=0x03, `co`=1, `done` in cycle 2.
- `in`=0x02, `cin`=1, ROTC, right, `count`=2 → `out`=0x40, `co`=1. Intermediate after step 1: 0x81, `co`=0.
- `in`=0xFF, LOGICAL, left, `count`=7 → `out`=0x80, `co`=1. Then `in`=0x01, LOGICAL, right, `count`=1 → `out`=0x00, `co`=1, `zero`=1.
- `count`=0, `in`=0x5A, `cin`=1 → `done` in cycle 1 with `out`=0x5A, `co`=1. `start` pulsed during SHIFT of a count-5 operation → ignored, exactly one `done`.
- `rst_n`=0 in the third SHIFT cycle of a count-6 operation → next edge: `busy`=0, `out`=0, `co`=0, `zero`=1, `done` never asserted. A subsequent `start` works normally.
